// File: rtl/pipo_pkg.sv
// Shared definitions for the PIPO holding register: default width and parity helper.
// The parity helper is used by the optional PIPO_PARITY_EN build and by benches.
package pipo_pkg;

   localparam int PIPO_DEFAULT_WIDTH = 4;
   localparam int PIPO_MAX_WIDTH     = 64;

   // Callers zero-extend narrower words; the XOR reduction is unaffected by it.
   function automatic logic pipo_parity(input logic [PIPO_MAX_WIDTH-1:0] word);
      return ^word;
   endfunction

endpackage : pipo_pkg

// File: rtl/pipo_parity_gen.sv
// Combinational even-parity (XOR reduction) of a WIDTH-bit word.
// Instantiated by pipo_register only when PIPO_PARITY_EN is defined.
module pipo_parity_gen
   import pipo_pkg::*;
#(
   parameter int WIDTH = PIPO_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] word_in,
   output logic             parity
);

   logic [PIPO_MAX_WIDTH-1:0] word_ext_s;

   // Zero-extend the word to the helper's fixed argument width.
   always_comb begin
      word_ext_s              = {PIPO_MAX_WIDTH{1'b0}};
      word_ext_s[WIDTH-1:0]   = word_in;
      parity                  = pipo_parity(word_ext_s);
   end

endmodule : pipo_parity_gen

// File: rtl/pipo_register.sv
// Parallel-in/parallel-out holding register with sticky 'loaded' flag.
// Defining PIPO_PARITY_EN adds a registered even-parity output aligned with data_out.
module pipo_register
   import pipo_pkg::*;
#(
   parameter int               WIDTH       = PIPO_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             loaded
`ifdef PIPO_PARITY_EN
   ,
   output logic             parity_out
`endif
);

   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] data_q;
   logic             loaded_d;
   logic             loaded_q;

   // Next-state selection between capture and hold; reset is applied in the flop block.
   always_comb begin
      data_d   = data_q;
      loaded_d = loaded_q;
      if (load) begin
         data_d   = data_in;
         loaded_d = 1'b1;
      end else begin
         data_d   = data_q;
         loaded_d = loaded_q;
      end
   end

   // Data and status flops with synchronous active-low reset taking priority over load.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         data_q   <= RESET_VALUE;
         loaded_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         loaded_q <= loaded_d;
      end
   end

   assign data_out = data_q;
   assign loaded   = loaded_q;

`ifdef PIPO_PARITY_EN
   logic parity_d;
   logic parity_rst_s;
   logic parity_q;

   pipo_parity_gen #(
      .WIDTH   (WIDTH)
   ) u_parity_gen (
      .word_in (data_d),
      .parity  (parity_d)
   );

   pipo_parity_gen #(
      .WIDTH   (WIDTH)
   ) u_parity_rst (
      .word_in (RESET_VALUE),
      .parity  (parity_rst_s)
   );

   // Parity flop tracks data_q exactly, including the reset value.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         parity_q <= parity_rst_s;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity_out = parity_q;
`endif

endmodule : pipo_register

// File: tb/tb_pipo_register.sv
// Self-checking bench for pipo_register: directed test-plan cases plus randomized
// traffic checked against a behavioural model (parity checked when PIPO_PARITY_EN).
module tb_pipo_register;

   localparam int WIDTH = 4;
   localparam logic [WIDTH-1:0] RV = 4'h0;

   logic             clock;
   logic             reset_n;
   logic             load;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             loaded;
`ifdef PIPO_PARITY_EN
   logic             parity_out;
`endif

   int n_cmp;
   int n_mis;
   bit clk_run;

   logic [WIDTH-1:0] exp_data;
   logic             exp_loaded;

   pipo_register #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RV)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .data_in    (data_in),
      .data_out   (data_out),
      .loaded     (loaded)
`ifdef PIPO_PARITY_EN
      ,
      .parity_out (parity_out)
`endif
   );

   // Free-running clock that can be frozen (only while low) for the no-clock test.
   always begin
      #5;
      if (clk_run) clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      if (observed !== expected) begin
         n_mis++;
         $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One rising edge: model samples the inputs at the edge, outputs checked on the falling edge.
   task automatic tick();
      @(posedge clock);
      if (reset_n == 1'b0) begin
         exp_data   = RV;
         exp_loaded = 1'b0;
      end else if (load == 1'b1) begin
         exp_data   = data_in;
         exp_loaded = 1'b1;
      end
      @(negedge clock);
      check("data_out", {28'd0, data_out}, {28'd0, exp_data});
      check("loaded", {31'd0, loaded}, {31'd0, exp_loaded});
`ifdef PIPO_PARITY_EN
      check("parity_out", {31'd0, parity_out}, ($countones(exp_data) % 2 == 1) ? 32'd1 : 32'd0);
`endif
   endtask

   initial begin
      n_cmp    = 0;
      n_mis    = 0;
      clock    = 1'b0;
      clk_run  = 1'b1;
      reset_n  = 1'b0;
      load     = 1'b1;
      data_in  = 4'hF;
      exp_data = 4'h0;
      exp_loaded = 1'b0;

      // Reset held for two edges with a competing load.
      @(negedge clock);
      tick();
      tick();
      check("reset_data", {28'd0, data_out}, 32'h0);
      check("reset_loaded", {31'd0, loaded}, 32'd0);

      // Basic load.
      reset_n = 1'b1;
      load    = 1'b1;
      data_in = 4'b1010;
      tick();
      check("basic_load", {28'd0, data_out}, 32'hA);
      check("basic_loaded", {31'd0, loaded}, 32'd1);

      // Hold for ten edges with changed data_in.
      load    = 1'b0;
      data_in = 4'b0101;
      for (int i = 0; i < 10; i++) tick();
      check("hold", {28'd0, data_out}, 32'hA);

      // Load pulse while clock is frozen low.
      clk_run = 1'b0;
      #20;
      load    = 1'b1;
      data_in = 4'b0111;
      #3;
      load    = 1'b0;
      #7;
      check("noclk_pulse", {28'd0, data_out}, 32'hA);
      clk_run = 1'b1;
      tick();
      check("noclk_edge", {28'd0, data_out}, 32'hA);

      // Back-to-back loads.
      load    = 1'b1;
      data_in = 4'h3;
      tick();
      check("b2b_3", {28'd0, data_out}, 32'h3);
      data_in = 4'hC;
      tick();
      check("b2b_c", {28'd0, data_out}, 32'hC);
      data_in = 4'h7;
      tick();
      check("b2b_7", {28'd0, data_out}, 32'h7);

      // Reset overriding a simultaneous load.
      reset_n = 1'b0;
      load    = 1'b1;
      data_in = 4'h9;
      tick();
      check("midrst_data", {28'd0, data_out}, 32'h0);
      check("midrst_loaded", {31'd0, loaded}, 32'd0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 300; i++) begin
         reset_n = ($urandom_range(0, 19) != 0);
         load    = $urandom_range(0, 1) == 1;
         data_in = 4'($urandom);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_pipo_register
